// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the CSR initiator and its bench.
package axi4_pkg;

   typedef enum logic [2:0] {
      MST_IDLE  = 3'd0,
      MST_RADDR = 3'd1,
      MST_RDATA = 3'd2,
      MST_WADDR = 3'd3,
      MST_WRESP = 3'd4,
      MST_RSP   = 3'd5
   } MstState_t;

   localparam logic [2:0] AXI_SIZE_32B   = 3'b010;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] INCR   = 2'b01;

endpackage

// File: rtl/axi4_if.sv
// AXI4 signal bundle with initiator and responder views; IDs are IDLEN bits wide.
interface axi4 #(parameter int IDLEN = 4);
   logic             ar_valid, ar_ready;
   logic [31:0]      ar_addr;
   logic [IDLEN-1:0] ar_id;
   logic [7:0]       ar_len;
   logic [2:0]       ar_size;
   logic [1:0]       ar_burst;
   logic             aw_valid, aw_ready;
   logic [31:0]      aw_addr;
   logic [IDLEN-1:0] aw_id;
   logic [7:0]       aw_len;
   logic [2:0]       aw_size;
   logic [1:0]       aw_burst;
   logic             w_valid, w_ready;
   logic [31:0]      w_data;
   logic [3:0]       w_strb;
   logic             w_last;
   logic             b_valid, b_ready;
   logic [1:0]       b_resp;
   logic [IDLEN-1:0] b_id;
   logic             r_valid, r_ready;
   logic [31:0]      r_data;
   logic [1:0]       r_resp;
   logic [IDLEN-1:0] r_id;
   logic             r_last;

   modport master (
      output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
      output w_valid, w_data, w_strb, w_last, b_ready, r_ready,
      input  ar_ready, aw_ready, w_ready,
      input  b_valid, b_resp, b_id,
      input  r_valid, r_data, r_resp, r_id, r_last
   );

   modport slave (
      input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
      input  w_valid, w_data, w_strb, w_last, b_ready, r_ready,
      output ar_ready, aw_ready, w_ready,
      output b_valid, b_resp, b_id,
      output r_valid, r_data, r_resp, r_id, r_last
   );
endinterface

// File: rtl/axi4_csr_master.sv
// Single-outstanding AXI4 initiator turning a valid/ready CSR request into one
// single-beat read or write, returning a held response.
module axi4_csr_master
   import axi4_pkg::*;
#(
   parameter int AXI_ID   = 0,
   parameter int ID_W     = 4,
   parameter bit STRB_ALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   axi4.master         bus,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_strb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam logic [ID_W-1:0] ID_VAL = ID_W'(AXI_ID);

   MstState_t   r_state;
   logic        r_req_ready, r_ar_valid, r_aw_valid, r_w_valid;
   logic        r_aw_done, r_w_done, r_r_ready, r_b_ready;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_strb;
   logic        r_rsp_valid, r_rsp_err;
   logic [31:0] r_rsp_rdata;

   logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

   function automatic logic rsp_is_err(input logic [1:0] resp, input logic [ID_W-1:0] id,
                                       input logic last);
      return (resp != OKAY) | (id != ID_VAL) | ~last;
   endfunction

   // AW and W complete independently; a handshake this cycle counts as done
   assign w_aw_hs  = r_aw_valid & bus.aw_ready;
   assign w_w_hs   = r_w_valid & bus.w_ready;
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done | w_w_hs;

   // Transaction FSM with all bus and response outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= MST_IDLE;
         r_req_ready <= 1'b0;
         r_ar_valid  <= 1'b0;
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_r_ready   <= 1'b0;
         r_b_ready   <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_strb      <= 4'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            MST_IDLE: begin
               if (req_valid_i && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_addr      <= req_addr_i;
                  r_wdata     <= req_wdata_i;
                  r_strb      <= req_strb_i;
                  if (req_we_i) begin
                     r_state    <= MST_WADDR;
                     r_aw_valid <= 1'b1;
                     r_w_valid  <= 1'b1;
                     r_aw_done  <= 1'b0;
                     r_w_done   <= 1'b0;
                  end else begin
                     r_state    <= MST_RADDR;
                     r_ar_valid <= 1'b1;
                  end
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            MST_RADDR: begin
               if (bus.ar_ready) begin
                  r_ar_valid <= 1'b0;
                  r_r_ready  <= 1'b1;
                  r_state    <= MST_RDATA;
               end
            end
            MST_RDATA: begin
               if (bus.r_valid) begin
                  r_r_ready   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= bus.r_data;
                  r_rsp_err   <= rsp_is_err(bus.r_resp, bus.r_id, bus.r_last);
                  r_state     <= MST_RSP;
               end
            end
            MST_WADDR: begin
               if (w_aw_hs) begin
                  r_aw_valid <= 1'b0;
                  r_aw_done  <= 1'b1;
               end
               if (w_w_hs) begin
                  r_w_valid <= 1'b0;
                  r_w_done  <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_b_ready <= 1'b1;
                  r_state   <= MST_WRESP;
               end
            end
            MST_WRESP: begin
               if (bus.b_valid) begin
                  r_b_ready   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 32'h0;
                  r_rsp_err   <= rsp_is_err(bus.b_resp, bus.b_id, 1'b1);
                  r_state     <= MST_RSP;
               end
            end
            MST_RSP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= MST_IDLE;
               end
            end
            default: begin
               r_state     <= MST_IDLE;
               r_req_ready <= 1'b0;
               r_ar_valid  <= 1'b0;
               r_aw_valid  <= 1'b0;
               r_w_valid   <= 1'b0;
               r_r_ready   <= 1'b0;
               r_b_ready   <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = r_req_ready;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_rdata_o  = r_rsp_rdata;
   assign rsp_err_o    = r_rsp_err;

   assign bus.ar_valid = r_ar_valid;
   assign bus.ar_addr  = r_addr;
   assign bus.ar_id    = ID_VAL;
   assign bus.ar_len   = AXI_LEN_SINGLE;
   assign bus.ar_size  = AXI_SIZE_32B;
   assign bus.ar_burst = INCR;
   assign bus.aw_valid = r_aw_valid;
   assign bus.aw_addr  = r_addr;
   assign bus.aw_id    = ID_VAL;
   assign bus.aw_len   = AXI_LEN_SINGLE;
   assign bus.aw_size  = AXI_SIZE_32B;
   assign bus.aw_burst = INCR;
   assign bus.w_valid  = r_w_valid;
   assign bus.w_data   = r_wdata;
   assign bus.w_strb   = STRB_ALL ? 4'hF : r_strb;
   assign bus.w_last   = 1'b1;
   assign bus.r_ready  = r_r_ready;
   assign bus.b_ready  = r_b_ready;

endmodule
